// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, majority-of-three sampling per bit,
// optional even/odd parity, registered one-cycle result strobes.
module uart_rx #(
    parameter int PRESCALE = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic [7:0] P_DATA,
    output logic       DATA_VALID,
    output logic       PAR_ERR,
    output logic       STP_ERR,
    output logic       BUSY
);
    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] C_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] C_S0   = CW'(PRESCALE / 2 - 1);
    localparam logic [CW-1:0] C_S1   = CW'(PRESCALE / 2);
    localparam logic [CW-1:0] C_S2   = CW'(PRESCALE / 2 + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    function automatic logic par8(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    state_t          r_state, w_next;
    logic            r_sync1, r_rx_s;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_cnt;
    logic [2:0]      r_samp;
    logic [7:0]      r_shift;
    logic            r_par_en, r_par_typ, r_par_mis;
    logic [7:0]      r_p_data;
    logic            r_dv, r_pe, r_se, r_busy;

    logic            w_bit_end, w_maj;
    logic            w_start, w_shift_en, w_par_chk, w_dv, w_pe, w_se;

    assign w_bit_end = (r_cnt == C_LAST);
    assign w_maj     = maj3(r_samp);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= RX_IN;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // A low line at the end of a good stop bit is the next start bit, so go
    // straight to START to keep back-to-back frames aligned.
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_shift_en = 1'b0;
        w_par_chk  = 1'b0;
        w_dv       = 1'b0;
        w_pe       = 1'b0;
        w_se       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_rx_s) begin
                    w_next  = START;
                    w_start = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            START: begin
                if (w_bit_end) w_next = w_maj ? IDLE : DATA;
                else           w_next = START;
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) w_next = r_par_en ? PARITY : STOP;
                    else                   w_next = DATA;
                end else begin
                    w_next = DATA;
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_par_chk = 1'b1;
                    w_next    = STOP;
                end else begin
                    w_next = PARITY;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (w_maj) begin
                        w_pe = r_par_mis;
                        w_dv = ~r_par_mis;
                        if (!r_rx_s) begin
                            w_next  = START;
                            w_start = 1'b1;
                        end else begin
                            w_next = IDLE;
                        end
                    end else begin
                        w_se   = 1'b1;
                        w_pe   = r_par_mis;
                        w_next = WAIT_HIGH;
                    end
                end else begin
                    w_next = STOP;
                end
            end
            WAIT_HIGH: begin
                if (r_rx_s) w_next = IDLE;
                else        w_next = WAIT_HIGH;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt     <= '0;
            r_bit_cnt <= 3'd0;
            r_samp    <= 3'b111;
            r_shift   <= 8'h00;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_par_mis <= 1'b0;
        end else begin
            if (w_start || r_state == IDLE || r_state == WAIT_HIGH || w_bit_end)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(1);
            if (r_cnt == C_S0) r_samp[0] <= r_rx_s;
            if (r_cnt == C_S1) r_samp[1] <= r_rx_s;
            if (r_cnt == C_S2) r_samp[2] <= r_rx_s;
            if (w_start) begin
                r_bit_cnt <= 3'd0;
                r_par_en  <= PAR_EN;
                r_par_typ <= PAR_TYP;
                r_par_mis <= 1'b0;
            end else begin
                if (w_shift_en) begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    r_shift   <= {w_maj, r_shift[7:1]};
                end
                if (w_par_chk) r_par_mis <= (par8(r_shift, r_par_typ) != w_maj);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_p_data <= 8'h00;
            r_dv     <= 1'b0;
            r_pe     <= 1'b0;
            r_se     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            if (w_dv) r_p_data <= r_shift;
            r_dv   <= w_dv;
            r_pe   <= w_pe;
            r_se   <= w_se;
            r_busy <= (w_next != IDLE);
        end
    end

    assign P_DATA     = r_p_data;
    assign DATA_VALID = r_dv;
    assign PAR_ERR    = r_pe;
    assign STP_ERR    = r_se;
    assign BUSY       = r_busy;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed vector table, corner-case sequences and random
// frames scored against a frame-level reference model.
module tb_uart_rx;
    localparam int P = 8;

    logic       CLK = 1'b0;
    logic       RST, RX_IN, PAR_EN, PAR_TYP;
    logic [7:0] P_DATA;
    logic       DATA_VALID, PAR_ERR, STP_ERR, BUSY;

    uart_rx #(.PRESCALE(P)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR),
        .STP_ERR(STP_ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;
    always @(posedge CLK) edge_cnt++;

    typedef struct {
        int         cyc;
        logic       dv, pe, se;
        logic [7:0] data;
    } ev_t;
    ev_t act_q[$];
    ev_t exp_q[$];

    int   busy_rise = -1;
    int   busy_fall = -1;
    logic prev_busy = 1'b0;

    // Event cycle = the edge at which the registered strobe is present.
    always @(negedge CLK) begin
        if (BUSY && !prev_busy) busy_rise = edge_cnt + 1;
        if (!BUSY && prev_busy) busy_fall = edge_cnt + 1;
        prev_busy = BUSY;
        if (DATA_VALID || PAR_ERR || STP_ERR)
            act_q.push_back('{edge_cnt + 1, DATA_VALID, PAR_ERR, STP_ERR, P_DATA});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) tick();
    endtask

    // Drives one frame bit by bit; optional single inverted sample per data bit,
    // optional mid-frame scrambling of PAR_EN/PAR_TYP, optional abort by reset.
    task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit,
                              input bit stp, input int flip_j, input bit scramble,
                              input int abort_b, output int start);
        logic [10:0] bits;
        int nb;
        nb = pen ? 11 : 10;
        bits = 11'h7FF;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[k+1] = d[k];
        if (pen) begin
            bits[9]  = pbit;
            bits[10] = stp;
        end else begin
            bits[9] = stp;
        end
        start = edge_cnt + 1;
        for (int b = 0; b < nb; b++) begin
            if (b == abort_b) begin
                RST = 1'b1;
                return;
            end
            if (scramble && b == 5) begin
                PAR_EN  = 1'($urandom);
                PAR_TYP = 1'($urandom);
            end
            for (int j = 0; j < P; j++) begin
                RX_IN = (j == flip_j && b >= 1 && b <= 8) ? ~bits[b] : bits[b];
                tick();
            end
        end
    endtask

    logic [7:0] last_good;

    // Frame-level reference: outcome and its cycle follow from the frame bits.
    task automatic model_frame(input int start, input logic [7:0] d, input bit pen,
                               input bit ptyp, input bit pbit, input bit stp);
        int  n;
        bit  mism;
        n    = pen ? 11 : 10;
        mism = pen && (pbit != ((^d) ^ ptyp));
        if (!stp) begin
            exp_q.push_back('{start + 3 + n * P, 1'b0, mism, 1'b1, last_good});
        end else if (mism) begin
            exp_q.push_back('{start + 3 + n * P, 1'b0, 1'b1, 1'b0, last_good});
        end else begin
            last_good = d;
            exp_q.push_back('{start + 3 + n * P, 1'b1, 1'b0, 1'b0, d});
        end
    endtask

    task automatic compare_events(input string tag);
        check({tag, "_count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            check({tag, "_cycle"}, act_q[i].cyc, exp_q[i].cyc);
            check({tag, "_flags"}, {act_q[i].dv, act_q[i].pe, act_q[i].se},
                  {exp_q[i].dv, exp_q[i].pe, exp_q[i].se});
            check({tag, "_data"}, act_q[i].data, exp_q[i].data);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0] data;
        bit         pen, ptyp, pbit, stp;
        int         gap;
        logic       edv, epe, ese;
        logic [7:0] edata;
        int         lat;
    } vec_t;
    vec_t vt[8];

    initial begin
        int st, h, prev_gap;
        vt[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0, 8'hA5, 83};
        vt[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0, 8'h3C, 91};
        vt[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 16, 1'b0, 1'b1, 1'b0, 8'h3C, 91};
        vt[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 0,  1'b1, 1'b0, 1'b0, 8'h01, 91};
        vt[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 0,  1'b1, 1'b0, 1'b0, 8'hFF, 91};
        vt[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0, 8'h80, 91};
        vt[6] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 40, 1'b0, 1'b0, 1'b1, 8'h80, 83};
        vt[7] = '{8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0, 8'h12, 83};

        RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) tick();
        check("rst_p_data", P_DATA, 8'h00);
        check("rst_data_valid", DATA_VALID, 1'b0);
        check("rst_par_err", PAR_ERR, 1'b0);
        check("rst_stp_err", STP_ERR, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        RST = 1'b0;
        idle(4);

        prev_gap = 1;
        foreach (vt[i]) begin
            PAR_EN  = vt[i].pen;
            PAR_TYP = vt[i].ptyp;
            send_frame(vt[i].data, vt[i].pen, vt[i].pbit, vt[i].stp, -1, 1'b0, -1, st);
            exp_q.push_back('{st + vt[i].lat, vt[i].edv, vt[i].epe, vt[i].ese, vt[i].edata});
            if (!vt[i].stp) begin
                repeat (vt[i].gap) tick();
                h = edge_cnt + 1;
                idle(2 * P);
                check("break_busy_fall", busy_fall, h + 3);
            end else begin
                idle(vt[i].gap);
                if (vt[i].gap > 0 && prev_gap > 0) begin
                    check("busy_rise", busy_rise, st + 3);
                    check("busy_fall", busy_fall, st + vt[i].lat);
                end
            end
            prev_gap = vt[i].gap;
        end
        idle(2 * P);
        compare_events("table");

        // Short low glitch in IDLE, then a frame with one bad sample per data bit.
        RX_IN = 1'b0;
        h = edge_cnt + 1;
        repeat (2) tick();
        idle(3 * P);
        check("glitch_busy_rise", busy_rise, h + 3);
        check("glitch_busy_len", busy_fall - busy_rise, P);
        PAR_EN = 1'b0;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 5, 1'b0, -1, st);
        exp_q.push_back('{st + 83, 1'b1, 1'b0, 1'b0, 8'hC3});
        idle(2 * P);
        compare_events("glitch");

        // Reset during data bit 4 aborts the frame without any strobe.
        send_frame(8'h99, 1'b0, 1'b0, 1'b1, -1, 1'b0, 5, st);
        #1;
        check("abort_p_data", P_DATA, 8'h00);
        check("abort_busy", BUSY, 1'b0);
        RX_IN = 1'b1;
        repeat (3) tick();
        RST = 1'b0;
        idle(4);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1, -1, 1'b0, -1, st);
        exp_q.push_back('{st + 83, 1'b1, 1'b0, 1'b0, 8'h7E});
        idle(2 * P);
        compare_events("abort");

        last_good = 8'h7E;
        for (int n = 0; n < 16; n++) begin
            logic [7:0] d;
            bit pen, ptyp, pbit, stp, good_par;
            int sel, fj;
            d        = 8'($urandom);
            pen      = 1'($urandom);
            ptyp     = 1'($urandom);
            good_par = ($urandom_range(0, 4) != 0);
            stp      = ($urandom_range(0, 7) != 0);
            pbit     = (^d) ^ ptyp ^ !good_par;
            sel      = $urandom_range(0, 3);
            fj       = (sel == 0) ? -1 : 3 + sel;
            PAR_EN   = pen;
            PAR_TYP  = ptyp;
            send_frame(d, pen, pbit, stp, fj, 1'b1, -1, st);
            model_frame(st, d, pen, ptyp, pbit, stp);
            if (!stp) begin
                repeat ($urandom_range(0, 20)) tick();
                idle(P);
            end else begin
                idle($urandom_range(0, 2) * P);
            end
        end
        idle(2 * P);
        compare_events("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
